// File: rtl/riscvlong_core_scoreboard.sv
// Register-hazard scoreboard for the D/X/M/X2/X3/W core: tracks in-flight rd writes,
// drives decode bypass selects and the RAW stall, and issues the W-stage regfile write.
module riscvlong_core_scoreboard (
  input  logic       clk,
  input  logic       reset,
  input  logic       inst_val_Dhl,
  input  logic       rs1_en_Dhl,
  input  logic       rs2_en_Dhl,
  input  logic [4:0] rs1_Dhl,
  input  logic [4:0] rs2_Dhl,
  input  logic       rf_wen_Dhl,
  input  logic [4:0] rf_waddr_Dhl,
  input  logic [1:0] rtype_Dhl,
  input  logic       squash_Dhl,
  input  logic       stall_Xhl,
  input  logic       stall_Mhl,
  input  logic       stall_X2hl,
  input  logic       stall_X3hl,
  input  logic       stall_Whl,
  output logic       raw_stall_Dhl,
  output logic       op0_byp_sel_Dhl,
  output logic       op1_byp_sel_Dhl,
  output logic [5:0] byp_mux_sel_Dhl,
  output logic       rf_wen_Whl,
  output logic [4:0] rf_waddr_Whl
);

  localparam int NUM_TRACK = 5;

  typedef struct packed {
    logic       val;
    logic       wen;
    logic [4:0] waddr;
    logic [1:0] rtype;
  } entry_t;

  localparam entry_t BUBBLE = '0;

  // Index 0 = X, 1 = M, 2 = X2, 3 = X3, 4 = W.
  entry_t ent [NUM_TRACK];

  logic [NUM_TRACK-1:0] stall;
  assign stall = {stall_Whl, stall_X3hl, stall_X2hl, stall_Mhl, stall_Xhl};

  // First stage index from which a result of this class can be bypassed.
  function automatic logic [2:0] ready_idx(input logic [1:0] rtype);
    case (rtype)
      2'd0:    return 3'd0;
      2'd1:    return 3'd1;
      default: return 3'd3;
    endcase
  endfunction

  function automatic logic src_match(input entry_t e, input logic val, input logic en,
                                     input logic [4:0] r);
    return val && en && e.val && e.wen && (e.waddr == r) && (r != 5'd0);
  endfunction

  logic       hit0, hit1, rdy0, rdy1;
  logic [2:0] idx0, idx1;

  // Scan oldest to youngest so the youngest matching stage overwrites older ones.
  always_comb begin
    hit0 = 1'b0;
    hit1 = 1'b0;
    rdy0 = 1'b0;
    rdy1 = 1'b0;
    idx0 = 3'd0;
    idx1 = 3'd0;
    for (int s = NUM_TRACK - 1; s >= 0; s--) begin
      if (src_match(ent[s], inst_val_Dhl, rs1_en_Dhl, rs1_Dhl)) begin
        hit0 = 1'b1;
        idx0 = 3'(s);
        rdy0 = (3'(s) >= ready_idx(ent[s].rtype));
      end
      if (src_match(ent[s], inst_val_Dhl, rs2_en_Dhl, rs2_Dhl)) begin
        hit1 = 1'b1;
        idx1 = 3'(s);
        rdy1 = (3'(s) >= ready_idx(ent[s].rtype));
      end
    end
  end

  assign raw_stall_Dhl   = ((hit0 && !rdy0) || (hit1 && !rdy1)) && !squash_Dhl;
  assign op0_byp_sel_Dhl = hit0 && rdy0;
  assign op1_byp_sel_Dhl = hit1 && rdy1;
  assign byp_mux_sel_Dhl = {op1_byp_sel_Dhl ? idx1 : 3'd0, op0_byp_sel_Dhl ? idx0 : 3'd0};

  assign rf_wen_Whl   = ent[NUM_TRACK-1].val && ent[NUM_TRACK-1].wen && !stall_Whl;
  assign rf_waddr_Whl = ent[NUM_TRACK-1].waddr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < NUM_TRACK; s++) ent[s] <= BUBBLE;
    end else begin
      if (!stall[0]) begin
        if (!inst_val_Dhl || raw_stall_Dhl || squash_Dhl) ent[0] <= BUBBLE;
        // x0 writes are tracked with wen cleared so they never match or write back.
        else ent[0] <= '{val: 1'b1, wen: rf_wen_Dhl && (rf_waddr_Dhl != 5'd0),
                         waddr: rf_waddr_Dhl, rtype: rtype_Dhl};
      end
      for (int s = 1; s < NUM_TRACK; s++) begin
        if (!stall[s]) ent[s] <= stall[s-1] ? BUBBLE : ent[s-1];
      end
    end
  end

endmodule

// File: tb/tb_riscvlong_core_scoreboard.sv
// Bench for riscvlong_core_scoreboard: directed hazard scenarios plus randomized traffic
// checked against a stage-list reference model and an ordered write-back queue.
module tb_riscvlong_core_scoreboard;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       inst_val_Dhl = 1'b0, rs1_en_Dhl = 1'b0, rs2_en_Dhl = 1'b0;
  logic [4:0] rs1_Dhl = '0, rs2_Dhl = '0, rf_waddr_Dhl = '0;
  logic       rf_wen_Dhl = 1'b0, squash_Dhl = 1'b0;
  logic [1:0] rtype_Dhl = '0;
  logic       stall_Xhl = 1'b0, stall_Mhl = 1'b0, stall_X2hl = 1'b0, stall_X3hl = 1'b0,
              stall_Whl = 1'b0;
  logic       raw_stall_Dhl, op0_byp_sel_Dhl, op1_byp_sel_Dhl, rf_wen_Whl;
  logic [5:0] byp_mux_sel_Dhl;
  logic [4:0] rf_waddr_Whl;

  riscvlong_core_scoreboard dut (
    .clk(clk), .reset(reset), .inst_val_Dhl(inst_val_Dhl),
    .rs1_en_Dhl(rs1_en_Dhl), .rs2_en_Dhl(rs2_en_Dhl), .rs1_Dhl(rs1_Dhl), .rs2_Dhl(rs2_Dhl),
    .rf_wen_Dhl(rf_wen_Dhl), .rf_waddr_Dhl(rf_waddr_Dhl), .rtype_Dhl(rtype_Dhl),
    .squash_Dhl(squash_Dhl), .stall_Xhl(stall_Xhl), .stall_Mhl(stall_Mhl),
    .stall_X2hl(stall_X2hl), .stall_X3hl(stall_X3hl), .stall_Whl(stall_Whl),
    .raw_stall_Dhl(raw_stall_Dhl), .op0_byp_sel_Dhl(op0_byp_sel_Dhl),
    .op1_byp_sel_Dhl(op1_byp_sel_Dhl), .byp_mux_sel_Dhl(byp_mux_sel_Dhl),
    .rf_wen_Whl(rf_wen_Whl), .rf_waddr_Whl(rf_waddr_Whl)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Each stage holds the instruction occupying it; rdy is the earliest stage it can bypass from.
  typedef struct {
    bit val;
    bit wen;
    int rd;
    int rdy;
  } m_ent_t;

  m_ent_t     m_pipe [5];
  m_ent_t     m_next [5];
  m_ent_t     bubble = '{0, 0, 0, 0};
  logic [4:0] exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         dut_stall_seen;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int class_ready(input int rt);
    if (rt == 0) return 0;
    if (rt == 1) return 1;
    return 3;
  endfunction

  function automatic void m_resolve(input bit en, input int r, output bit hit,
                                    output bit rdy, output int idx);
    hit = 0; rdy = 0; idx = 0;
    if (!inst_val_Dhl || !en || r == 0) return;
    for (int s = 0; s < 5; s++) begin
      if (m_pipe[s].val && m_pipe[s].wen && m_pipe[s].rd == r) begin
        hit = 1; idx = s; rdy = (s >= m_pipe[s].rdy);
        return;
      end
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input bit v, input bit e1, input int r1, input bit e2, input int r2,
                       input bit w, input int rd, input int rt, input bit sq);
    inst_val_Dhl = v; rs1_en_Dhl = e1; rs1_Dhl = 5'(r1); rs2_en_Dhl = e2; rs2_Dhl = 5'(r2);
    rf_wen_Dhl = w; rf_waddr_Dhl = 5'(rd); rtype_Dhl = 2'(rt); squash_Dhl = sq;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // k = number of leading stages (from X) held by the global stall.
  task automatic set_stall(input int k);
    stall_Xhl = (k > 0); stall_Mhl = (k > 1); stall_X2hl = (k > 2);
    stall_X3hl = (k > 3); stall_Whl = (k > 4);
  endtask

  // Called right after inputs are driven at a falling edge; checks, then advances one clock.
  task automatic cycle();
    bit h0, r0, h1, r1, e_stall, e_wen;
    int i0, i1;
    bit st [5];
    logic [2:0] s0, s1;
    #1;
    if (!reset) begin
      for (int s = 0; s < 5; s++) m_pipe[s] = bubble;
      exp_q.delete();
    end
    m_resolve(rs1_en_Dhl, rs1_Dhl, h0, r0, i0);
    m_resolve(rs2_en_Dhl, rs2_Dhl, h1, r1, i1);
    e_stall = ((h0 && !r0) || (h1 && !r1)) && !squash_Dhl;
    dut_stall_seen = raw_stall_Dhl;
    check_eq("raw_stall", raw_stall_Dhl, e_stall);
    if (!e_stall && !squash_Dhl) begin
      s0 = h0 ? 3'(i0) : 3'd0;
      s1 = h1 ? 3'(i1) : 3'd0;
      check_eq("op0_byp_sel", op0_byp_sel_Dhl, h0);
      check_eq("op1_byp_sel", op1_byp_sel_Dhl, h1);
      check_eq("byp_mux_sel", byp_mux_sel_Dhl, {s1, s0});
    end
    e_wen = m_pipe[4].val && m_pipe[4].wen && !stall_Whl;
    check_eq("rf_wen_W", rf_wen_Whl, e_wen);
    if (e_wen) begin
      check_eq("rf_waddr_W", rf_waddr_Whl, m_pipe[4].rd);
      if (exp_q.size() > 0) check_eq("write_order", rf_waddr_Whl, exp_q.pop_front());
      else check_eq("write_queue_len", exp_q.size(), 1);
    end
    st[0] = stall_Xhl; st[1] = stall_Mhl; st[2] = stall_X2hl; st[3] = stall_X3hl;
    st[4] = stall_Whl;
    m_next = m_pipe;
    if (reset) begin
      if (!st[0]) begin
        if (!inst_val_Dhl || e_stall || squash_Dhl) m_next[0] = bubble;
        else begin
          m_next[0] = '{1, rf_wen_Dhl && rf_waddr_Dhl != 0, int'(rf_waddr_Dhl),
                        class_ready(int'(rtype_Dhl))};
          if (m_next[0].wen) exp_q.push_back(rf_waddr_Dhl);
        end
      end
      for (int s = 1; s < 5; s++)
        if (!st[s]) m_next[s] = st[s-1] ? bubble : m_pipe[s-1];
    end
    @(posedge clk);
    m_pipe = m_next;
    @(negedge clk);
  endtask

  // Hold a consumer in D until the DUT stops stalling; returns the stall-cycle count.
  task automatic hold_consumer(output int cnt);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (!dut_stall_seen) return;
      cnt++;
    end
    check_eq("stall_timeout", cnt, 0);
  endtask

  int n_st;

  initial begin
    for (int s = 0; s < 5; s++) m_pipe[s] = bubble;
    nop(); set_stall(0);
    @(negedge clk);
    cycle(); cycle();
    reset = 1'b1;

    // ALU chain: dependent reader of x5 walks selects X, M, X2, X3, W, then regfile.
    drive(1, 0, 0, 0, 0, 1, 5, 0, 0); cycle();
    for (int i = 0; i < 6; i++) begin
      drive(1, 1, 5, 0, 0, 1, 10 + i, 0, 0);
      #1;
      check_eq("alu_chain_sel", byp_mux_sel_Dhl[2:0], (i < 5) ? i : 0);
      cycle();
    end

    // Load-use: exactly one stall, then bypass from M on op1.
    drive(1, 0, 0, 0, 0, 1, 7, 1, 0); cycle();
    drive(1, 0, 0, 1, 7, 1, 11, 0, 0); hold_consumer(n_st);
    check_eq("load_use_stalls", n_st, 1);
    nop(); repeat (5) cycle();

    // Muldiv: three stalls, then both operands from X3.
    drive(1, 0, 0, 0, 0, 1, 9, 2, 0); cycle();
    drive(1, 1, 9, 1, 9, 1, 12, 0, 0); hold_consumer(n_st);
    check_eq("muldiv_stalls", n_st, 3);
    nop(); repeat (5) cycle();

    // Priority: x3 in both X and W -> X wins; x0 writes never match.
    drive(1, 0, 0, 0, 0, 1, 3, 0, 0); cycle();
    nop(); repeat (3) cycle();
    drive(1, 0, 0, 0, 0, 1, 3, 0, 0); cycle();
    drive(1, 1, 3, 1, 3, 0, 0, 0, 0); #1;
    check_eq("prio_sel", byp_mux_sel_Dhl, 6'b000000);
    check_eq("prio_byp", {op1_byp_sel_Dhl, op0_byp_sel_Dhl}, 2'b11);
    cycle();
    drive(1, 0, 0, 0, 0, 1, 0, 1, 0); cycle();
    drive(1, 1, 0, 1, 0, 1, 13, 0, 0); cycle();
    nop(); repeat (5) cycle();

    // Stall X..X2 for two cycles with a full pipe, then squash a dependent consumer.
    for (int i = 1; i <= 4; i++) begin drive(1, 0, 0, 0, 0, 1, i, 0, 0); cycle(); end
    set_stall(3); cycle(); cycle();
    set_stall(0); nop(); repeat (6) cycle();
    drive(1, 0, 0, 0, 0, 1, 6, 2, 0); cycle();
    drive(1, 1, 6, 0, 0, 1, 14, 0, 1); cycle();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
    nop(); repeat (5) cycle();

    // Reset with stale entries: outputs drop at once, no writes after release.
    for (int i = 20; i < 24; i++) begin drive(1, 1, i - 1, 0, 0, 1, i, 0, 0); cycle(); end
    drive(1, 1, 23, 1, 22, 1, 25, 0, 0);
    reset = 1'b0; #1;
    check_eq("rst_raw_stall", raw_stall_Dhl, 0);
    check_eq("rst_byp_sel", {op1_byp_sel_Dhl, op0_byp_sel_Dhl, byp_mux_sel_Dhl}, 0);
    check_eq("rst_rf_wen", rf_wen_Whl, 0);
    check_eq("rst_rf_waddr", rf_waddr_Whl, 0);
    cycle(); cycle();
    reset = 1'b1; nop(); repeat (5) cycle();

    // Randomized traffic with coherent (prefix) stalls, squashes and occasional resets.
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 1), $urandom_range(0, 4),
            $urandom_range(0, 1), $urandom_range(0, 4), $urandom_range(0, 3) != 0,
            $urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 19) == 0);
      set_stall($urandom_range(0, 9) < 8 ? 0 : $urandom_range(1, 5));
      reset = ($urandom_range(0, 99) != 0);
      cycle();
    end
    reset = 1'b1; set_stall(0); nop(); repeat (6) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/riscvlong_core_scoreboard.md
# riscvlong_core_scoreboard

Register-hazard scoreboard for the 5-stage-plus-long-pipe RISC-V core (D, X, M, X2, X3, W). It tracks destination-register writes for every in-flight instruction from X through W. From that state it drives the decode-stage operand bypass selects, and it raises the decode RAW stall when a needed result has not yet reached a bypassable point. It also produces the final register-file write enable and address for W. It sits in the control unit beside the datapath and replaces the per-stage hand-written hazard logic.

## Interface
- NUM_TRACK, 5, number of tracked stages (X, M, X2, X3, W); fixed, not user-changeable
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- inst_val_Dhl  in  1  valid instruction in D
- rs1_en_Dhl, rs2_en_Dhl  in  1 each  instruction reads rs1 / rs2
- rs1_Dhl, rs2_Dhl  in  5 each  source register addresses
- rf_wen_Dhl  in  1  instruction writes rd
- rf_waddr_Dhl  in  5  rd address
- rtype_Dhl  in  2  result class:
  - 0 = ALU, ready from X
  - 1 = load, ready from M
  - 2 = muldiv, ready from X3
  - 3 = reserved, treated as muldiv
- squash_Dhl  in  1  kill instruction in D (taken branch resolved in X)
- stall_Xhl, stall_Mhl, stall_X2hl, stall_X3hl, stall_Whl  in  1 each  stage hold from global stall logic
- raw_stall_Dhl  out  1  D must hold: operand result not yet bypassable
- op0_byp_sel_Dhl, op1_byp_sel_Dhl  out  1 each  0 = regfile data, 1 = bypass network
- byp_mux_sel_Dhl  out  6  [2:0] op0 source, [5:3] op1 source:
  - 0 = X, 1 = M, 2 = X2, 3 = X3, 4 = W
- rf_wen_Whl  out  1  register-file write enable
- rf_waddr_Whl  out  5  register-file write address

## Operation
- Per tracked stage s the block holds an entry {val, wen, waddr[4:0], rtype[1:0]}. Stage index is X=0, M=1, X2=2, X3=3, W=4.
- Ready rule: entry at stage s is ready when its stage index ≥ ready index of its rtype (ALU 0, load 1, muldiv 2..3 → 3).
- Match: entry matches source r when all of the following hold: val && wen && waddr == r && r != 0 && the corresponding rsN_en_Dhl && inst_val_Dhl.
- Per operand, the youngest matching stage wins (X > M > X2 > X3 > W).
  - If the winning entry is ready: byp_sel = 1 and the select field = that stage index.
  - If it is not ready: raw_stall_Dhl = 1.
  - With no match: byp_sel = 0 and the select field = 0.
- Both operands resolve independently. If rs1 == rs2 they produce identical selects.
- raw_stall_Dhl = OR of the two per-operand not-ready conditions. It is forced to 0 when squash_Dhl = 1.
- Advance, per clock edge, for each stage s in {M, X2, X3, W}:
  - if stall_s = 1: hold
  - else if the previous stage is stalled: load a bubble (val = 0)
  - else: copy the previous entry
- X stage:
  - if stall_Xhl = 1: hold
  - else if !inst_val_Dhl, raw_stall_Dhl or squash_Dhl: load a bubble
  - else: load {1, rf_wen_Dhl, rf_waddr_Dhl, rtype_Dhl}
- A write to x0 is recorded with wen = 0.
- rf_wen_Whl = val_W && wen_W && !stall_Whl. rf_waddr_Whl = waddr_W.

## Timing
- Reset (reset = 0, asynchronous): all entries have val = 0 and waddr = 0.
  - Outputs: raw_stall_Dhl = 0, byp selects = 0, rf_wen_Whl = 0, rf_waddr_Whl = 0.
  - Release is sampled synchronously. The first entry is captured on the first rising edge with reset = 1.
- Bypass and stall outputs are combinational from the registered entries plus the D inputs. There is no added latency.
- An instruction accepted in D at edge n occupies X after edge n and W after edge n+4, assuming no stalls.
- An ALU producer followed directly by a dependent consumer causes no stall. A load followed directly by a dependent consumer causes 1 stall cycle. A muldiv followed directly by a dependent consumer causes 3 stall cycles.
- Reset asserted mid-operation discards all tracked entries immediately. No write enable is issued afterwards.

## Test plan
- Reset with stale entries: assert reset = 0 mid-stream → all outputs 0 the same cycle, rf_wen_Whl stays 0 for 5 cycles after release with inst_val_Dhl = 0.
- ALU chain: ADD x5 (rtype 0) then dependent on rs1 = x5 next cycle → raw_stall_Dhl = 0, op0_byp_sel = 1, byp_mux_sel[2:0] = 0. Next-next consumer gets sel 1. Four cycles later the consumer gets sel 4. After that it reads the regfile (sel 0).
- Load-use: LW x7 then rs2 = x7 → raw_stall_Dhl = 1 for exactly 1 cycle. Then op1_byp_sel = 1, byp_mux_sel[5:3] = 1. A bubble appears in X during the stall.
- Muldiv: MUL x9 then rs1 = rs2 = x9 → 3 stall cycles. Then both selects = 3 and byp_mux_sel = 6'b011011.
- Priority/x0: x3 written in X and in W, consumer reads x3 → sel 0 (X). A consumer reading x0 with an x0 write in flight → byp_sel = 0, no stall.
- Stall/squash: stall_X2hl = 1 for 2 cycles → X2 and upstream hold, X3 receives bubbles, rf_wen_Whl drops. A dependent instruction with squash_Dhl = 1 gets raw_stall_Dhl = 0 and X receives a bubble.
